// File: rtl/xbus_rr_interconnect.sv
// ---------------------------------------------------------------------------
// xbus_rr_interconnect
//   N-master / M-slave simulation-bus interconnect with registered round-robin
//   arbitration. One transaction is in flight at a time: the winning master is
//   locked until its transaction completes, is aborted, or times out. The target
//   slave is decoded from the top SEL_WIDTH address bits.
//
//   Optional feature (compile-time macro XBUS_TIMEOUT_EN):
//     defined   - BUSY gives up after TIMEOUT_CYCLES cycles without ack and
//                 completes with m_err=1.
//     undefined - no timeout counter; BUSY waits for ack indefinitely.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   m_req          per-master request, held until m_done
//   m_we           per-master write(1)/read(0)
//   m_addr         flattened addresses, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   m_wdata        flattened write data, master i at [i*DATA_WIDTH +: DATA_WIDTH]
//   m_gnt          one-hot registered grant
//   m_done         one-cycle completion pulse to the granted master
//   m_rdata        read data, valid with m_done (0 on writes and errors)
//   m_err          error flag, valid with m_done
//   s_sel          one-hot slave select (BUSY only)
//   s_we/s_addr/s_wdata  command latched from the granted master
//   s_rdata        flattened slave read data
//   s_ack          slave completion, only the selected slave's bit is used
//   master_id_out  index of the granted master
//   hold_flag_out  1 while a transaction is in flight (BUSY or DONE)
// ---------------------------------------------------------------------------
module xbus_rr_interconnect #(
  parameter int NUM_MASTERS    = 4,
  parameter int NUM_SLAVES     = 8,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_WIDTH      = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_MASTERS-1:0]             m_req,
  input  logic [NUM_MASTERS-1:0]             m_we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]  m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]  m_wdata,
  output logic [NUM_MASTERS-1:0]             m_gnt,
  output logic [NUM_MASTERS-1:0]             m_done,
  output logic [DATA_WIDTH-1:0]              m_rdata,
  output logic                               m_err,
  output logic [NUM_SLAVES-1:0]              s_sel,
  output logic                               s_we,
  output logic [ADDR_WIDTH-1:0]              s_addr,
  output logic [DATA_WIDTH-1:0]              s_wdata,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0]   s_rdata,
  input  logic [NUM_SLAVES-1:0]              s_ack,
  output logic [$clog2(NUM_MASTERS)-1:0]     master_id_out,
  output logic                               hold_flag_out
);

  localparam int MID_W = $clog2(NUM_MASTERS);

  // Reject configurations the decode and arbitration logic cannot support.
  if (NUM_MASTERS < 2 || NUM_SLAVES > (1 << SEL_WIDTH) || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("xbus_rr_interconnect: unsupported parameter combination");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [MID_W-1:0]        rr_ptr;

  logic                    win_found;
  logic [MID_W-1:0]        win_idx;
  int                      scan_j;

  logic [SEL_WIDTH-1:0]    sel_idx;
  logic [NUM_SLAVES-1:0]   sel_dec;
  logic                    sel_ok;
  logic                    ack_sel;
  logic [DATA_WIDTH-1:0]   rdata_sel;
  logic                    gnt_req;

`ifdef XBUS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]        tmo_cnt;
`endif

  // Round-robin pointer after serving (or aborting) master id.
  function automatic logic [MID_W-1:0] ptr_after(input logic [MID_W-1:0] id);
    if (int'(id) == NUM_MASTERS - 1) return '0;
    return id + 1'b1;
  endfunction

  // Arbitration: first requester scanning rr_ptr, rr_ptr+1, ... with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_j    = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      scan_j = int'(rr_ptr) + k;
      if (scan_j >= NUM_MASTERS) scan_j = scan_j - NUM_MASTERS;
      if (!win_found && m_req[scan_j]) begin
        win_found = 1'b1;
        win_idx   = MID_W'(scan_j);
      end
    end
  end

  // Slave decode from the latched address; an index past the last slave
  // matches nothing, which is how a bad decode is detected.
  assign sel_idx = s_addr[ADDR_WIDTH-1 -: SEL_WIDTH];

  always_comb begin
    sel_dec   = '0;
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      if (32'(sel_idx) == 32'(s)) begin
        sel_dec[s] = 1'b1;
        ack_sel    = s_ack[s];
        rdata_sel  = s_rdata[s*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign sel_ok  = |sel_dec;
  assign gnt_req = |(m_req & m_gnt);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. Abort outranks completion: a master that has let go of
  // its request is no longer waiting for a done pulse.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (win_found) state_d = BUSY;
      BUSY: begin
        if (!gnt_req)     state_d = IDLE;
        else if (!sel_ok) state_d = DONE;
        else if (ack_sel) state_d = DONE;
`ifdef XBUS_TIMEOUT_EN
        else if (32'(tmo_cnt) == 32'(TIMEOUT_CYCLES - 1)) state_d = DONE;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    s_sel         = '0;
    hold_flag_out = 1'b0;
    m_done        = '0;
    case (state_q)
      BUSY: begin
        s_sel         = sel_dec;
        hold_flag_out = 1'b1;
      end
      DONE: begin
        hold_flag_out = 1'b1;
        m_done        = m_gnt;
      end
      default: ;
    endcase
  end

  // Grant, command latch, response and pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      m_gnt         <= '0;
      master_id_out <= '0;
      s_we          <= 1'b0;
      s_addr        <= '0;
      s_wdata       <= '0;
      m_rdata       <= '0;
      m_err         <= 1'b0;
      rr_ptr        <= '0;
`ifdef XBUS_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
`ifdef XBUS_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          if (win_found) begin
            m_gnt         <= NUM_MASTERS'(1) << win_idx;
            master_id_out <= win_idx;
            s_we          <= m_we[win_idx];
            s_addr        <= m_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            s_wdata       <= m_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        BUSY: begin
          if (state_d == IDLE) begin
            m_gnt         <= '0;
            master_id_out <= '0;
            s_we          <= 1'b0;
            s_addr        <= '0;
            s_wdata       <= '0;
            rr_ptr        <= ptr_after(master_id_out);
          end else if (state_d == DONE) begin
            // Covers ack, bad decode and (when enabled) timeout; a same-cycle
            // ack always yields a clean completion.
            m_err   <= !(sel_ok && ack_sel);
            m_rdata <= (sel_ok && ack_sel && !s_we) ? rdata_sel : '0;
          end
`ifdef XBUS_TIMEOUT_EN
          else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          m_gnt         <= '0;
          master_id_out <= '0;
          s_we          <= 1'b0;
          s_addr        <= '0;
          s_wdata       <= '0;
          m_rdata       <= '0;
          m_err         <= 1'b0;
          rr_ptr        <= ptr_after(master_id_out);
        end
        default: ;
      endcase
    end
  end

endmodule
